ts_packet_aligner: RTL and testbench

TS_PACKET_ALIGNER -- requirements
Module: ts_packet_aligner

---
 rtl/ts_packet_aligner.sv | 129 ++++++++++++
 tb/tb_ts_packet_aligner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ts_packet_aligner: finds TS sync, locks, emits whole aligned packets.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ts_packet_aligner #(
  parameter logic [7:0] SYNC_BYTE    = 8'h47,
  parameter int          PKT_LEN      = 188,
  parameter int          LOCK_COUNT   = 3,
  parameter int          UNLOCK_COUNT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        D_VALID_IN,
  output logic [7:0]  DATA_OUT,
  output logic        D_VALID_OUT,
  output logic        P_SYNC_OUT,
  output logic        LOCKED,
  output logic [15:0] PKT_CNT,
  output logic [7:0]  ERR_CNT
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] c_last   = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0] c_one    = IDX_W'((PKT_LEN > 1) ? 1 : 0);
  localparam logic [7:0]       c_lock   = 8'(LOCK_COUNT);
  localparam logic [7:0]       c_unlock = 8'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_good;
  logic [7:0]       r_miss;

  logic             w_is_sync;
  logic             w_idx_zero;
  logic [IDX_W-1:0] w_idx_next;
  logic [7:0]       w_err_inc;

  assign w_is_sync  = (DATA_IN == SYNC_BYTE);
  assign w_idx_zero = (r_idx == '0);
  assign w_idx_next = (r_idx == c_last) ? '0 : r_idx + IDX_W'(1);
  assign w_err_inc  = (ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_HUNT;
      r_idx       <= '0;
      r_good      <= 8'd0;
      r_miss      <= 8'd0;
      DATA_OUT    <= 8'h00;
      D_VALID_OUT <= 1'b0;
      P_SYNC_OUT  <= 1'b0;
      LOCKED      <= 1'b0;
      PKT_CNT     <= 16'd0;
      ERR_CNT     <= 8'd0;
    end else begin
      D_VALID_OUT <= 1'b0;
      P_SYNC_OUT  <= 1'b0;
      if (D_VALID_IN) begin
        case (r_state)
          S_HUNT: begin
            // Any sync-valued byte is a candidate; VERIFY weeds out payload hits.
            if (w_is_sync) begin
              r_state <= S_VERIFY;
              r_idx   <= c_one;
              r_good  <= 8'd1;
            end
          end
          S_VERIFY: begin
            r_idx <= w_idx_next;
            if (w_idx_zero) begin
              if (w_is_sync) begin
                r_good <= r_good + 8'd1;
                if (r_good + 8'd1 >= c_lock) begin
                  r_state     <= S_LOCKED;
                  r_miss      <= 8'd0;
                  LOCKED      <= 1'b1;
                  DATA_OUT    <= DATA_IN;
                  D_VALID_OUT <= 1'b1;
                  P_SYNC_OUT  <= 1'b1;
                  PKT_CNT     <= PKT_CNT + 16'd1;
                end
              end else begin
                r_state <= S_HUNT;
                r_good  <= 8'd0;
                r_idx   <= '0;
              end
            end
          end
          S_LOCKED: begin
            r_idx <= w_idx_next;
            if (w_idx_zero && !w_is_sync && (r_miss + 8'd1 >= c_unlock)) begin
              // Dropping lock only at index 0 keeps every emitted packet whole.
              r_state <= S_HUNT;
              r_idx   <= '0;
              r_good  <= 8'd0;
              r_miss  <= 8'd0;
              LOCKED  <= 1'b0;
              ERR_CNT <= w_err_inc;
            end else begin
              DATA_OUT    <= DATA_IN;
              D_VALID_OUT <= 1'b1;
              if (w_idx_zero) begin
                P_SYNC_OUT <= 1'b1;
                PKT_CNT    <= PKT_CNT + 16'd1;
                if (w_is_sync) begin
                  r_miss <= 8'd0;
                end else begin
                  r_miss  <= r_miss + 8'd1;
                  ERR_CNT <= w_err_inc;
                end
              end
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ts_packet_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ts_packet_aligner: directed self-checking bench for ts_packet_aligner.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ts_packet_aligner;

  logic        CLK;
  logic        RST;
  logic [7:0]  DATA_IN;
  logic        D_VALID_IN;
  logic [7:0]  DATA_OUT;
  logic        D_VALID_OUT;
  logic        P_SYNC_OUT;
  logic        LOCKED;
  logic [15:0] PKT_CNT;
  logic [7:0]  ERR_CNT;

  int n_assert = 0;
  int n_fail   = 0;

  ts_packet_aligner dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .D_VALID_IN (D_VALID_IN),
    .DATA_OUT   (DATA_OUT),
    .D_VALID_OUT(D_VALID_OUT),
    .P_SYNC_OUT (P_SYNC_OUT),
    .LOCKED     (LOCKED),
    .PKT_CNT    (PKT_CNT),
    .ERR_CNT    (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Payload values 1..64: never the sync byte and never 0x00.
  function automatic logic [7:0] pay(input int k);
    return 8'((k & 63) + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One valid byte; outputs are sampled 1 time unit after the edge that registers it.
  task automatic send_byte(input logic [7:0] d);
    DATA_IN    = d;
    D_VALID_IN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] sync, input bit out0,
                          input bit rest, input bit lk0, input bit gaps);
    int bad = 0;
    logic [7:0] b;
    for (int k = 0; k < 188; k++) begin
      if (gaps) begin
        int g = $urandom_range(0, 1);
        repeat (g) begin
          DATA_IN    = 8'h47;
          D_VALID_IN = 1'b0;
          @(posedge CLK);
          #1;
          if (D_VALID_OUT !== 1'b0 || P_SYNC_OUT !== 1'b0) bad++;
        end
      end
      b = (k == 0) ? sync : pay(k);
      send_byte(b);
      if (k == 0) begin
        chk({tag, ".vld0"}, 32'(D_VALID_OUT), 32'(out0));
        chk({tag, ".psync0"}, 32'(P_SYNC_OUT), 32'(out0));
        chk({tag, ".locked0"}, 32'(LOCKED), 32'(lk0));
        if (out0) chk({tag, ".data0"}, 32'(DATA_OUT), 32'(sync));
      end else if (D_VALID_OUT !== rest || P_SYNC_OUT !== 1'b0 ||
                   (rest && DATA_OUT !== b)) begin
        bad++;
      end
    end
    chk({tag, ".body_errs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad;
    RST        = 1'b0;
    DATA_IN    = 8'h00;
    D_VALID_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.data", 32'(DATA_OUT), 32'h00);
    chk("rst.vld", 32'(D_VALID_OUT), 32'd0);
    chk("rst.psync", 32'(P_SYNC_OUT), 32'd0);
    chk("rst.locked", 32'(LOCKED), 32'd0);
    chk("rst.pkt_cnt", 32'(PKT_CNT), 32'd0);
    chk("rst.err_cnt", 32'(ERR_CNT), 32'd0);
    RST = 1'b1;

    // Clean stream: lock on the third sync
    send_pkt("clean1", 8'h47, 0, 0, 0, 0);
    send_pkt("clean2", 8'h47, 0, 0, 0, 0);
    send_pkt("clean3", 8'h47, 1, 1, 1, 0);
    chk("clean.pkt_cnt", 32'(PKT_CNT), 32'd1);
    send_pkt("clean4", 8'h47, 1, 1, 1, 0);
    chk("clean.pkt_cnt2", 32'(PKT_CNT), 32'd2);

    // Two corrupted syncs stay locked; a good sync clears the miss count
    send_pkt("bad1", 8'h00, 1, 1, 1, 0);
    send_pkt("bad2", 8'h00, 1, 1, 1, 0);
    chk("bad.err_cnt", 32'(ERR_CNT), 32'd2);
    send_pkt("good5", 8'h47, 1, 1, 1, 0);
    send_pkt("bad3", 8'h00, 1, 1, 1, 0);
    send_pkt("bad4", 8'h00, 1, 1, 1, 0);
    send_pkt("good8", 8'h47, 1, 1, 1, 0);
    chk("miss_clear.err_cnt", 32'(ERR_CNT), 32'd4);
    chk("miss_clear.pkt_cnt", 32'(PKT_CNT), 32'd8);

    // Three consecutive bad syncs: unlock on the third, then relock
    send_pkt("ul1", 8'h00, 1, 1, 1, 0);
    send_pkt("ul2", 8'h00, 1, 1, 1, 0);
    send_pkt("ul3", 8'h00, 0, 0, 0, 0);
    chk("unlock.err_cnt", 32'(ERR_CNT), 32'd7);
    chk("unlock.pkt_cnt", 32'(PKT_CNT), 32'd10);
    send_pkt("rl1", 8'h47, 0, 0, 0, 0);
    send_pkt("rl2", 8'h47, 0, 0, 0, 0);
    send_pkt("rl3", 8'h47, 1, 1, 1, 0);
    chk("relock.pkt_cnt", 32'(PKT_CNT), 32'd11);

    // Random input gaps while locked
    send_pkt("gap1", 8'h47, 1, 1, 1, 1);
    send_pkt("gap2", 8'h47, 1, 1, 1, 1);
    chk("gap.pkt_cnt", 32'(PKT_CNT), 32'd13);
    chk("gap.err_cnt", 32'(ERR_CNT), 32'd7);

    // Async reset at byte 100 of a locked packet
    send_byte(8'h47);
    for (int k = 1; k < 100; k++) send_byte(pay(k));
    chk("pre_rst.pkt_cnt", 32'(PKT_CNT), 32'd14);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst.vld", 32'(D_VALID_OUT), 32'd0);
    chk("mid_rst.data", 32'(DATA_OUT), 32'h00);
    chk("mid_rst.locked", 32'(LOCKED), 32'd0);
    chk("mid_rst.pkt_cnt", 32'(PKT_CNT), 32'd0);
    chk("mid_rst.err_cnt", 32'(ERR_CNT), 32'd0);
    D_VALID_IN = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // False candidate at payload byte 50, then the real stream
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      send_byte(pay(k));
      if (D_VALID_OUT !== 1'b0) bad++;
    end
    send_byte(8'h47);
    if (D_VALID_OUT !== 1'b0) bad++;
    for (int k = 0; k < 37; k++) begin
      send_byte(pay(k));
      if (D_VALID_OUT !== 1'b0) bad++;
    end
    chk("false.no_out", 32'(bad), 32'd0);
    send_pkt("fc1", 8'h47, 0, 0, 0, 0);
    send_pkt("fc2", 8'h47, 0, 0, 0, 0);
    send_pkt("fc3", 8'h47, 0, 0, 0, 0);
    send_pkt("fc4", 8'h47, 1, 1, 1, 0);
    chk("fc.pkt_cnt", 32'(PKT_CNT), 32'd1);
    chk("fc.err_cnt", 32'(ERR_CNT), 32'd0);

    D_VALID_IN = 1'b0;
    @(posedge CLK);
    #1;
    chk("idle.vld", 32'(D_VALID_OUT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
